mem_port_arbiter: RTL and testbench

//  Shares the single mem_controller port between the CPU instruction-fetch requester (I, read-only)
//  and the CPU load/store requester (D, read/write). Round-robin arbitration, one transaction

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one mem_controller port between the instruction-fetch (I) and
// load/store (D) requesters, with one transaction in flight and a bounded wait for read data.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_req_ready,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,
    output logic                i_rsp_err,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                d_rsp_err,
    output logic                mc_valid_out,
    output logic [ADDR_W-1:0]   mc_addr_out,
    output logic [DATA_W-1:0]   mc_wdata_out,
    output logic [DATA_W/8-1:0] mc_be_out,
    output logic                mc_read_en_out,
    output logic                mc_write_en_out,
    input  logic                mc_ready_in,
    input  logic                mc_rdata_valid_in,
    input  logic [DATA_W-1:0]   mc_rdata_in,
    output logic                busy_out
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nxt;
    logic              last_d, last_d_nxt;
    logic              owner_d, owner_d_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              mc_valid_nxt, rd_nxt, wr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [BE_W-1:0]   be_nxt;
    logic              i_ready_nxt, d_ready_nxt;
    logic              grant_d, grant_wr;
    logic              rsp_fire, rsp_err;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        state_nxt    = state;
        last_d_nxt   = last_d;
        owner_d_nxt  = owner_d;
        cnt_nxt      = cnt;
        mc_valid_nxt = mc_valid_out;
        addr_nxt     = mc_addr_out;
        wdata_nxt    = mc_wdata_out;
        be_nxt       = mc_be_out;
        rd_nxt       = mc_read_en_out;
        wr_nxt       = mc_write_en_out;
        i_ready_nxt  = 1'b0;
        d_ready_nxt  = 1'b0;
        grant_d      = 1'b0;
        grant_wr     = 1'b0;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;

        unique case (state)
            IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    // Under contention the side that did not win last time gets the port.
                    grant_d      = d_req_valid && (!i_req_valid || !last_d);
                    grant_wr     = grant_d && d_req_we;
                    owner_d_nxt  = grant_d;
                    last_d_nxt   = grant_d;
                    mc_valid_nxt = 1'b1;
                    addr_nxt     = grant_d ? d_req_addr : i_req_addr;
                    wdata_nxt    = grant_wr ? d_req_wdata : '0;
                    be_nxt       = grant_wr ? d_req_be : '0;
                    wr_nxt       = grant_wr;
                    rd_nxt       = !grant_wr;
                    i_ready_nxt  = !grant_d;
                    d_ready_nxt  = grant_d;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                if (mc_ready_in) begin
                    mc_valid_nxt = 1'b0;
                    rd_nxt       = 1'b0;
                    wr_nxt       = 1'b0;
                    if (mc_write_en_out) begin
                        rsp_fire  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // Data arriving on the final timeout cycle still counts as a good read.
                if (mc_rdata_valid_in) begin
                    rsp_fire  = 1'b1;
                    rsp_data  = mc_rdata_in;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rsp_fire  = 1'b1;
                    rsp_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            last_d          <= 1'b0;
            owner_d         <= 1'b0;
            cnt             <= '0;
            mc_valid_out    <= 1'b0;
            mc_addr_out     <= '0;
            mc_wdata_out    <= '0;
            mc_be_out       <= '0;
            mc_read_en_out  <= 1'b0;
            mc_write_en_out <= 1'b0;
            i_req_ready     <= 1'b0;
            d_req_ready     <= 1'b0;
            i_rsp_valid     <= 1'b0;
            i_rsp_data      <= '0;
            i_rsp_err       <= 1'b0;
            d_rsp_valid     <= 1'b0;
            d_rsp_data      <= '0;
            d_rsp_err       <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            state           <= state_nxt;
            last_d          <= last_d_nxt;
            owner_d         <= owner_d_nxt;
            cnt             <= cnt_nxt;
            mc_valid_out    <= mc_valid_nxt;
            mc_addr_out     <= addr_nxt;
            mc_wdata_out    <= wdata_nxt;
            mc_be_out       <= be_nxt;
            mc_read_en_out  <= rd_nxt;
            mc_write_en_out <= wr_nxt;
            i_req_ready     <= i_ready_nxt;
            d_req_ready     <= d_ready_nxt;
            i_rsp_valid     <= rsp_fire && !owner_d;
            i_rsp_data      <= owner_d ? '0 : rsp_data;
            i_rsp_err       <= rsp_err && !owner_d;
            d_rsp_valid     <= rsp_fire && owner_d;
            d_rsp_data      <= owner_d ? rsp_data : '0;
            d_rsp_err       <= rsp_err && owner_d;
            busy_out        <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts every output each cycle, and
// directed scenarios pin grant order, latency, write acks, timeouts and reset abandonment.
module tb_mem_port_arbiter;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_be;
    logic        mc_valid_out, mc_read_en_out, mc_write_en_out;
    logic [31:0] mc_addr_out, mc_wdata_out;
    logic [3:0]  mc_be_out;
    logic        mc_ready_in, mc_rdata_valid_in;
    logic [31:0] mc_rdata_in;
    logic        busy_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mc_valid_out(mc_valid_out), .mc_addr_out(mc_addr_out), .mc_wdata_out(mc_wdata_out),
        .mc_be_out(mc_be_out), .mc_read_en_out(mc_read_en_out), .mc_write_en_out(mc_write_en_out),
        .mc_ready_in(mc_ready_in), .mc_rdata_valid_in(mc_rdata_valid_in), .mc_rdata_in(mc_rdata_in),
        .busy_out(busy_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                 input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] dbe);
        @(posedge clk);
        #2;
        i_req_valid = iv;
        i_req_addr  = ia;
        d_req_valid = dv;
        d_req_we    = dwe;
        d_req_addr  = da;
        d_req_wdata = dwd;
        d_req_be    = dbe;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return i_req_ready;
            1:       return d_req_ready;
            2:       return i_rsp_valid;
            3:       return d_rsp_valid;
            4:       return busy_out && !mc_valid_out;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitSignal(input string name, input int which, input int max);
        for (int k = 0; k < max; k++) begin
            tick();
            if (probe(which) === 1'b1) break;
        end
        checkOutput(name, probe(which), 1);
    endtask

    task automatic waitIdle(input int max);
        for (int k = 0; k < max; k++) begin
            tick();
            if (busy_out === 1'b0) break;
        end
        checkOutput("idle_reached", busy_out, 0);
    endtask

    // Memory-controller stand-in: accepts after mc_ready_delay cycles, returns read data
    // mc_data_delay cycles after acceptance, and forgets pending data on reset.
    int          mc_ready_delay = 0;
    int          mc_data_delay  = 1;
    logic [31:0] mc_data_val    = 32'h0;
    initial begin
        int ready_cnt;
        int data_cd;
        ready_cnt = 0;
        data_cd   = 0;
        mc_ready_in = 1'b0;
        mc_rdata_valid_in = 1'b0;
        mc_rdata_in = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            mc_ready_in = 1'b0;
            mc_rdata_valid_in = 1'b0;
            mc_rdata_in = 32'h0;
            if (!rst) data_cd = 0;
            if (data_cd > 0) begin
                data_cd--;
                if (data_cd == 0) begin
                    mc_rdata_valid_in = 1'b1;
                    mc_rdata_in = mc_data_val;
                end
            end
            if (mc_valid_out === 1'b1) begin
                if (ready_cnt >= mc_ready_delay) begin
                    mc_ready_in = 1'b1;
                    ready_cnt = 0;
                    if (mc_read_en_out === 1'b1) data_cd = mc_data_delay;
                end else begin
                    ready_cnt++;
                end
            end else begin
                ready_cnt = 0;
            end
        end
    end

    // Transaction-level model: one pending request, who won it, and when it must complete.
    typedef struct packed {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        cur;
    bit          have_txn = 0, issued = 0, last_was_d = 0, in_reset = 0, model_ok = 0;
    int          deadline = 0;
    int          cyc = 0;
    bit          e_i_ready, e_d_ready, e_i_rsp, e_d_rsp, e_err;
    logic [31:0] e_data;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            e_i_ready = 0; e_d_ready = 0; e_i_rsp = 0; e_d_rsp = 0; e_err = 0; e_data = 32'h0;
            model_ok = 1;
            in_reset = (rst === 1'b0);
            if (in_reset) begin
                have_txn = 0; issued = 0; last_was_d = 0;
            end else if (!have_txn) begin
                if (i_req_valid || d_req_valid) begin
                    cur.d     = d_req_valid && !(i_req_valid && last_was_d);
                    cur.we    = cur.d && d_req_we;
                    cur.addr  = cur.d ? d_req_addr : i_req_addr;
                    cur.wdata = d_req_wdata;
                    cur.be    = cur.we ? d_req_be : 4'h0;
                    last_was_d = cur.d;
                    have_txn = 1;
                    issued = 0;
                    if (cur.d) e_d_ready = 1; else e_i_ready = 1;
                end
            end else if (!issued) begin
                if (mc_ready_in) begin
                    if (cur.we) begin
                        have_txn = 0;
                        e_d_rsp = 1;
                    end else begin
                        issued = 1;
                        deadline = cyc + TMO;
                    end
                end
            end else if (mc_rdata_valid_in || cyc == deadline) begin
                have_txn = 0;
                e_err  = !mc_rdata_valid_in;
                e_data = mc_rdata_valid_in ? mc_rdata_in : 32'h0;
                if (cur.d) e_d_rsp = 1; else e_i_rsp = 1;
            end
        end
    end

    int n_i_rdy = 0, n_d_rdy = 0, n_i_rsp = 0, n_d_rsp = 0, n_mc_valid = 0, last_mc_valid_cyc = 0;
    bit grant_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                checkOutput("busy", busy_out, have_txn);
                checkOutput("mc_valid", mc_valid_out, have_txn && !issued);
                checkOutput("i_req_ready", i_req_ready, e_i_ready);
                checkOutput("d_req_ready", d_req_ready, e_d_ready);
                checkOutput("i_rsp_valid", i_rsp_valid, e_i_rsp);
                checkOutput("d_rsp_valid", d_rsp_valid, e_d_rsp);
                if (have_txn && !issued) begin
                    checkOutput("mc_addr", mc_addr_out, cur.addr);
                    checkOutput("mc_be", mc_be_out, cur.be);
                    checkOutput("mc_read_en", mc_read_en_out, !cur.we);
                    checkOutput("mc_write_en", mc_write_en_out, cur.we);
                    if (cur.we) checkOutput("mc_wdata", mc_wdata_out, cur.wdata);
                end else begin
                    checkOutput("mc_rw_idle", {mc_read_en_out, mc_write_en_out}, 0);
                end
                if (e_i_rsp) begin
                    checkOutput("i_rsp_data", i_rsp_data, e_data);
                    checkOutput("i_rsp_err", i_rsp_err, e_err);
                end
                if (e_d_rsp) begin
                    checkOutput("d_rsp_data", d_rsp_data, e_data);
                    checkOutput("d_rsp_err", d_rsp_err, e_err);
                end
                if (in_reset) begin
                    checkOutput("reset_mc_fields", mc_addr_out | mc_wdata_out | 32'(mc_be_out), 0);
                    checkOutput("reset_rsp_fields", i_rsp_data | d_rsp_data | 32'({i_rsp_err, d_rsp_err}), 0);
                end
                if (i_req_ready === 1'b1) begin n_i_rdy++; grant_log.push_back(1'b0); end
                if (d_req_ready === 1'b1) begin n_d_rdy++; grant_log.push_back(1'b1); end
                if (i_rsp_valid === 1'b1) n_i_rsp++;
                if (d_rsp_valid === 1'b1) n_d_rsp++;
                if (mc_valid_out === 1'b1) begin n_mc_valid++; last_mc_valid_cyc = cyc; end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, base, went, vbase;
        rst = 1'b0;
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_be = 0;

        // Both requesters waiting through reset; D must win the first contention.
        $display("[TB] reset with both requesters valid, then alternating grants");
        applyStimulus(1, 32'h200, 1, 1, 32'h300, 32'hA5A5A5A5, 4'hF);
        repeat (3) tick();
        checkOutput("reset_no_ready", n_i_rdy + n_d_rdy, 0);
        checkOutput("reset_busy", busy_out, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mc_data_val = 32'h0BADF00D;
        for (int k = 0; k < 80 && grant_log.size() < 4; k++) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitIdle(40);
        checkOutput("grant_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            checkOutput("grant0_is_D", grant_log[0], 1);
            checkOutput("grant1_is_I", grant_log[1], 0);
            checkOutput("grant2_is_D", grant_log[2], 1);
            checkOutput("grant3_is_I", grant_log[3], 0);
        end

        $display("[TB] single I read with data two cycles after accept");
        mc_data_delay = 2;
        mc_data_val = 32'hDEADBEEF;
        base = n_d_rsp + n_d_rdy;
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        t0 = cyc;
        waitSignal("t2_i_ready", 0, 10);
        checkOutput("t2_mc_addr", mc_addr_out, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSignal("t2_i_rsp", 2, 20);
        checkOutput("t2_data", i_rsp_data, 32'hDEADBEEF);
        checkOutput("t2_err", i_rsp_err, 0);
        checkOutput("t2_latency", cyc - t0, 4);
        tick();
        checkOutput("t2_pulse_width", i_rsp_valid, 0);
        checkOutput("t2_d_silent", n_d_rsp + n_d_rdy - base, 0);

        $display("[TB] D write held off by mc_ready for five cycles");
        mc_ready_delay = 5;
        vbase = n_mc_valid;
        applyStimulus(0, 0, 1, 1, 32'h40, 32'h12345678, 4'b0011);
        waitSignal("t4_d_ready", 1, 10);
        checkOutput("t4_mc_addr", mc_addr_out, 32'h40);
        checkOutput("t4_mc_wdata", mc_wdata_out, 32'h12345678);
        checkOutput("t4_mc_be", mc_be_out, 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSignal("t4_d_rsp", 3, 30);
        checkOutput("t4_valid_cycles", n_mc_valid - vbase, 6);
        checkOutput("t4_ack_delay", cyc - last_mc_valid_cyc, 1);
        checkOutput("t4_ack_data", d_rsp_data, 0);
        checkOutput("t4_ack_err", d_rsp_err, 0);
        checkOutput("t4_no_wait", busy_out, 0);
        mc_ready_delay = 0;

        $display("[TB] I read timeout with late data");
        mc_data_delay = TMO + 3;
        mc_data_val = 32'h5555AAAA;
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0);
        waitSignal("t5_i_ready", 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSignal("t5_in_wait", 4, 10);
        went = cyc;
        waitSignal("t5_i_rsp", 2, TMO + 10);
        checkOutput("t5_timeout_cycles", cyc - went, TMO);
        checkOutput("t5_err", i_rsp_err, 1);
        checkOutput("t5_data", i_rsp_data, 0);
        base = n_i_rsp + n_d_rsp;
        repeat (TMO) tick();
        checkOutput("t5_stale_ignored", n_i_rsp + n_d_rsp - base, 0);

        $display("[TB] reset during WAIT, then a normal D read");
        mc_data_delay = 6;
        mc_data_val = 32'h77777777;
        applyStimulus(0, 0, 1, 0, 32'h80, 0, 0);
        waitSignal("t6_d_ready", 1, 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_in_wait", busy_out && !mc_valid_out, 1);
        base = n_i_rsp + n_d_rsp;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        checkOutput("t6_idle_after_reset", busy_out, 0);
        repeat (8) tick();
        checkOutput("t6_no_rsp", n_i_rsp + n_d_rsp - base, 0);
        mc_data_delay = 1;
        mc_data_val = 32'hCAFE0084;
        applyStimulus(0, 0, 1, 0, 32'h84, 0, 0);
        waitSignal("t6_d_ready2", 1, 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitSignal("t6_d_rsp", 3, 20);
        checkOutput("t6_data", d_rsp_data, 32'hCAFE0084);
        checkOutput("t6_err", d_rsp_err, 0);
        waitIdle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
